// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux round-robin scheduler:
//   - default payload width and channel count
//   - FSM state encoding (EMPTY / FULL)
//   - steering mode constants (round-robin / fixed select)
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_OUT_DEF  = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_rr_pick.sv
// ---------------------------------------------------------------------------
// demux_rr_pick
// Combinational cyclic priority search: returns the first enabled channel
// found when scanning start, start+1, ... (mod N_OUT).
// Ports:
//   ch_en   in  N_OUT  per-channel enable mask
//   start   in  SEL_W  index the scan begins at
//   cand    out SEL_W  first enabled index in cyclic order
//   cand_ok out 1      at least one channel is enabled
// ---------------------------------------------------------------------------
module demux_rr_pick #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [N_OUT-1:0] ch_en,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] cand,
  output logic             cand_ok
);

  int w_idx;

  // Scan offsets from farthest to nearest so the nearest enabled channel
  // is the last (winning) assignment.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    cand    = '0;
    cand_ok = 1'b0;
    w_idx   = 0;
    for (int k = N_OUT - 1; k >= 0; k--) begin
      w_idx = (int'(start) + k) % N_OUT;
      if (ch_en[w_idx]) begin
        cand    = SEL_W'(w_idx);
        cand_ok = 1'b1;
      end
    end
  end

endmodule : demux_rr_pick

// File: rtl/demux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// demux_rr_scheduler
// Sequencing front-end for a 1-to-N demultiplexer. Holds one registered
// beat and steers it to one output channel, chosen round-robin over ch_en
// (mode=0) or by sel (mode=1). Latency 1 cycle, 1 beat/cycle throughput.
// Ports:
//   clk       in  1       system clock, rising edge
//   rst_n     in  1       synchronous active-low reset
//   mode      in  1       0 = round-robin, 1 = fixed channel from sel
//   sel       in  SEL_W   target channel in fixed mode
//   ch_en     in  N_OUT   per-channel enable mask
//   in_data   in  DATA_W  input payload
//   in_valid  in  1       input beat present
//   in_ready  out 1       a beat can be captured this cycle
//   out_data  out DATA_W  registered payload shared by all channels
//   out_valid out N_OUT   one-hot valid for the held beat
//   out_ready in  N_OUT   per-channel ready
//   rr_ptr    out SEL_W   round-robin pointer (debug)
//   stall_cnt out 16      saturating stall counter, only when
//                         DEMUX_STALL_CNT_EN is defined
// ---------------------------------------------------------------------------
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_OUT-1:0]  ch_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [SEL_W-1:0]  rr_ptr
`ifdef DEMUX_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [N_OUT-1:0] ONE_HOT0 = N_OUT'(1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_OUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_out_data;
  logic [N_OUT-1:0]  r_out_valid;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic [SEL_W-1:0]  w_rr_cand;
  logic              w_rr_ok;
  logic [SEL_W-1:0]  w_cand;
  logic              w_cand_ok;
  logic              w_drain;
  logic              w_capture;
  logic              w_in_ready;

  demux_rr_pick #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_pick (
    .ch_en   (ch_en),
    .start   (r_rr_ptr),
    .cand    (w_rr_cand),
    .cand_ok (w_rr_ok)
  );

  // Target selection; only consumed at capture, so a held beat is never
  // re-targeted by later changes to mode/sel/ch_en.
  always_comb begin
    w_cand    = w_rr_cand;
    w_cand_ok = w_rr_ok;
    if (mode == MODE_FIXED) begin
      w_cand    = sel;
      w_cand_ok = ch_en[sel];
    end
  end

  // out_valid is one-hot while FULL, so masking with out_ready tests the
  // ready bit of the held beat's target.
  assign w_drain = (r_state == ST_FULL) && (|(r_out_valid & out_ready));

  // FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_capture)              w_state_nxt = ST_FULL;
      ST_FULL:  if (w_drain && !w_capture)  w_state_nxt = ST_EMPTY;
      default:                              w_state_nxt = ST_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_in_ready = w_cand_ok && ((r_state == ST_EMPTY) || w_drain);
    w_capture  = in_valid && w_in_ready;
  end

  // Datapath: held beat, its one-hot target and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_rr_ptr    <= '0;
    end else if (w_capture) begin
      r_out_data  <= in_data;
      r_out_valid <= ONE_HOT0 << w_cand;
      if (mode == MODE_RR)
        r_rr_ptr <= (w_cand == LAST_CH) ? '0 : w_cand + 1'b1;
    end else if (w_drain) begin
      r_out_valid <= '0;
    end
  end

`ifdef DEMUX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Counts cycles a held beat waits on its target's ready; saturates.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if ((r_state == ST_FULL) && !w_drain && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  // Stall counter not built in this configuration.
`endif

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign rr_ptr    = r_rr_ptr;

endmodule : demux_rr_scheduler

// File: tb/tb_demux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_scheduler
// Directed bench for demux_rr_scheduler (default parameters). Expected
// values are hand-computed constants. Inputs change 1 ns after a rising
// edge; outputs are checked in that same settled window.
// Honours DEMUX_STALL_CNT_EN for the optional stall counter.
// ---------------------------------------------------------------------------
module tb_demux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;
  logic [3:0] ch_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;
`ifdef DEMUX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .ch_en     (ch_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
`ifdef DEMUX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    ch_en     = 4'b1111;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 4'b1111;

    // Reset and hold
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_rr_ptr",    32'(rr_ptr),    32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_in_ready",  32'(in_ready),  32'h1);

    // Round-robin streaming, all channels enabled, pointer wraps 3 -> 0
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'hA0 + 8'(k);
      #1;
      check($sformatf("rr_in_ready_%0d", k), 32'(in_ready), 32'h1);
      step();
      check($sformatf("rr_out_valid_%0d", k), 32'(out_valid), 32'(4'b0001 << (k % 4)));
      check($sformatf("rr_out_data_%0d", k),  32'(out_data),  32'(8'hA0 + k));
      check($sformatf("rr_ptr_%0d", k),       32'(rr_ptr),    32'((k + 1) % 4));
    end
    in_valid = 1'b0;
    step();
    check("rr_drain_out_valid", 32'(out_valid), 32'h0);
    check("rr_drain_rr_ptr",    32'(rr_ptr),    32'h2);

    // Mask skip: bring rr_ptr back to 0, then only ch1/ch3 enabled
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mask_rr_ptr0", 32'(rr_ptr), 32'h0);
    ch_en    = 4'b1010;
    in_valid = 1'b1;
    in_data  = 8'hB0;
    step();
    check("mask_ov_0", 32'(out_valid), 32'b0010);
    check("mask_ptr_0", 32'(rr_ptr),  32'h2);
    in_data = 8'hB1;
    step();
    check("mask_ov_1", 32'(out_valid), 32'b1000);
    check("mask_ptr_1", 32'(rr_ptr),  32'h0);
    in_data = 8'hB2;
    step();
    check("mask_ov_2", 32'(out_valid), 32'b0010);
    check("mask_data_2", 32'(out_data), 32'hB2);
    in_valid = 1'b0;
    step();
    check("mask_drain_ov", 32'(out_valid), 32'h0);
    ch_en    = 4'b0000;
    in_valid = 1'b1;
    in_data  = 8'hBF;
    #1;
    check("noen_in_ready", 32'(in_ready), 32'h0);
    step();
    check("noen_out_valid", 32'(out_valid), 32'h0);
    check("noen_rr_ptr",    32'(rr_ptr),    32'h2);

    // Backpressure in fixed mode on ch2
    mode      = 1'b1;
    sel       = 2'd2;
    ch_en     = 4'b1111;
    out_ready = 4'b1011;
    in_data   = 8'h5C;
    step();
    check("bp_capture_ov", 32'(out_valid), 32'b0100);
    check("bp_fixed_ptr",  32'(rr_ptr),    32'h2);
    in_data = 8'h5D;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
      step();
      check($sformatf("bp_out_data_%0d", k),  32'(out_data),  32'h5C);
      check($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'b0100);
    end
`ifdef DEMUX_STALL_CNT_EN
    check("bp_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    out_ready = 4'b1111;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h1);
    step();
    check("bp_b2b_out_valid", 32'(out_valid), 32'b0100);
    check("bp_b2b_out_data",  32'(out_data),  32'h5D);
`ifdef DEMUX_STALL_CNT_EN
    check("bp_stall_hold", 32'(stall_cnt), 32'd5);
`endif

    // Sample-at-capture: retarget inputs while FULL on ch2
    out_ready = 4'b1011;
    in_valid  = 1'b0;
    sel       = 2'd0;
    ch_en     = 4'b1011;
    step();
    check("sac_held_ov",   32'(out_valid), 32'b0100);
    check("sac_held_data", 32'(out_data),  32'h5D);
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 8'h60;
    #1;
    check("sac_exit_ov", 32'(out_valid), 32'b0100);
    check("sac_in_ready", 32'(in_ready), 32'h1);
    step();
    check("sac_next_ov",   32'(out_valid), 32'b0001);
    check("sac_next_data", 32'(out_data),  32'h60);
    in_valid = 1'b0;
    step();
    check("sac_empty_ov", 32'(out_valid), 32'h0);

    // Reset mid-operation with a stalled beat
    mode      = 1'b0;
    ch_en     = 4'b1111;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    step();
    check("mid_capture_ov",  32'(out_valid), 32'b0100);
    check("mid_capture_ptr", 32'(rr_ptr),    32'h3);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    check("mid_rst_ov",   32'(out_valid), 32'h0);
    check("mid_rst_ptr",  32'(rr_ptr),    32'h0);
    check("mid_rst_data", 32'(out_data),  32'h0);
`ifdef DEMUX_STALL_CNT_EN
    check("mid_rst_stall", 32'(stall_cnt), 32'h0);
`endif
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid_after_ov_%0d", k), 32'(out_valid), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux_rr_scheduler

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
Sequencing front-end for the 1-to-N demultiplexer. Accepts a valid/ready input stream and steers each beat to one of N_OUT output channels, either round-robin over an enable mask or by explicit select. It holds one registered beat, so latency is 1 cycle, and it sustains 1 beat/cycle when the target channel is ready.

Parameters:
DATA_W, 8, payload width in bits
N_OUT, 4, number of output channels (>=2)
SEL_W, 2, select/pointer width; must equal clog2(N_OUT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
mode  in  1  0 = round-robin over ch_en, 1 = fixed channel given by sel
sel  in  SEL_W  target channel in fixed mode
ch_en  in  N_OUT  per-channel enable mask
in_data  in  DATA_W  input payload
in_valid  in  1  input beat present
in_ready  out  1  block can capture a beat this cycle
out_data  out  DATA_W  registered payload, common to all channels
out_valid  out  N_OUT  one-hot valid; bit i marks the beat for channel i
out_ready  in  N_OUT  per-channel ready
rr_ptr  out  SEL_W  current round-robin pointer (debug)

Behaviour:
- Reset is fixed: one clock, synchronous active-low reset on rst_n, sampled at the clk rising edge.
- Reset values: state=EMPTY, out_valid=0, out_data=0, rr_ptr=0. in_ready follows combinationally from the reset state.
- FSM has two states:
  - EMPTY: no beat is held.
  - FULL: one beat is held; out_valid has exactly one bit set (tgt).
- Beat leaves ("drain") when state==FULL and out_ready[tgt]==1.
- Target candidate "cand":
  - Round-robin (mode=0): first i in cyclic order rr_ptr, rr_ptr+1, ..., with ch_en[i]=1.
  - Fixed (mode=1): cand=sel, and it is valid only if ch_en[sel]=1.
  - cand_ok = 0 if there is no enabled candidate.
- in_ready = cand_ok && (state==EMPTY || drain).
- Capture = in_valid && in_ready. On capture:
  - out_data <= in_data
  - out_valid <= onehot(cand)
  - state <= FULL
  - in round-robin mode only: rr_ptr <= (cand+1) mod N_OUT
- Transitions:
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on drain without capture.
  - FULL -> FULL on drain with capture (back-to-back, 1 beat/cycle).
  - FULL with no drain: out_data, out_valid, tgt and rr_ptr all hold; in_ready=0.
- Latency: out_valid asserts the cycle after capture.
- mode, sel and ch_en are sampled only at capture. Changing them while FULL never re-targets or drops the held beat.
- ch_en all zero: in_ready=0. A held beat still drains normally.
- Pointer wrap: cand=N_OUT-1 gives rr_ptr=0. In fixed mode rr_ptr is unchanged.
- Reset mid-operation: the held beat is discarded and out_valid drops in the cycle after rst_n is sampled low.
- in_valid is never dropped; the block needs no input stability beyond standard valid/ready rules.

Optional Feature:
- Macro DEMUX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Increments by 1 each cycle with state==FULL and out_ready[tgt]==0.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - localparam defaults for DATA_W and N_OUT
  - state encoding EMPTY=1'b0, FULL=1'b1
  - mode constants MODE_RR=1'b0, MODE_FIXED=1'b1
- One sub-module, demux_rr_pick: a combinational cyclic priority search.
  - Inputs: ch_en, start index.
  - Outputs: cand, cand_ok.
- The FSM, registers and pointer stay in the top level.

Test Plan:
- Reset and hold: rst_n=0 for 2 cycles, all out_ready=1 -> out_valid=0, rr_ptr=0, out_data=0. Release with no in_valid -> state stays EMPTY.
- Round-robin streaming: mode=0, ch_en=4'b1111, out_ready=4'b1111, in_valid held with data 8'hA0..A5 -> out_valid sequence 0001, 0010, 0100, 1000, 0001, 0010 on consecutive cycles, each one cycle after capture. rr_ptr wraps 3 -> 0.
- Mask skip: mode=0, ch_en=4'b1010, rr_ptr=0 -> beats land on ch1, ch3, ch1. ch_en=0 -> in_ready=0 and no capture.
- Backpressure: mode=1, sel=2, out_ready[2]=0 for 5 cycles -> in_ready=0, out_data stable at 8'h5C, out_valid=0100. With DEMUX_STALL_CNT_EN, stall_cnt=5. Raising out_ready[2] with in_valid=1 -> drain and capture in the same cycle.
- Sample-at-capture: while FULL on ch2, change sel to 0 and clear ch_en[2] -> held beat still exits on ch2. The next beat goes to ch0.
- Reset mid-operation: FULL with out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0 and rr_ptr=0 the next cycle, and the held beat never appears.
